// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO management initiator
// Serialises one read or write frame per accepted command and returns read data and TA status.
module mdio_master #(
   parameter int CLK_DIV       = 25,
   parameter int PREAMBLE_BITS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy,
   input  logic [4:0]  cmd_reg,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_t,
   input  logic        mdio_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_TA,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [8:0] CNT_HALF = 9'(CLK_DIV);
   localparam logic [8:0] CNT_LAST = 9'(2 * CLK_DIV - 1);
   localparam logic [4:0] PRE_LAST = 5'((PREAMBLE_BITS > 0) ? (PREAMBLE_BITS - 1) : 0);

   state_t      r_state, w_nxt_state;
   logic [8:0]  r_cnt, w_nxt_cnt;
   logic [4:0]  r_bit, w_nxt_bit;
   logic [31:0] r_tx, w_nxt_tx;
   logic        r_write, w_nxt_write;
   logic [15:0] r_rx, w_nxt_rx;
   logic        r_ta2, w_nxt_ta2;
   logic        r_rsp_valid, w_nxt_rsp_valid;
   logic [15:0] r_rsp_rdata, w_nxt_rsp_rdata;
   logic        r_rsp_err, w_nxt_rsp_err;
   logic        r_mdc, w_nxt_mdc;
   logic        r_mdio_o, w_nxt_mdio_o;
   logic        r_mdio_t, w_nxt_mdio_t;

   logic        w_bit_end;
   logic        w_sample;
   logic [4:0]  w_last_bit;

   assign w_bit_end  = (r_cnt == CNT_LAST);
   assign w_sample   = (r_cnt == CNT_HALF);
   assign w_last_bit = (r_state == S_PRE) ? PRE_LAST :
                       (r_state == S_HDR) ? 5'd13    :
                       (r_state == S_TA)  ? 5'd1     : 5'd15;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_tx        <= '0;
         r_write     <= 1'b0;
         r_rx        <= '0;
         r_ta2       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mdc       <= 1'b0;
         r_mdio_o    <= 1'b1;
         r_mdio_t    <= 1'b1;
      end else begin
         r_state     <= w_nxt_state;
         r_cnt       <= w_nxt_cnt;
         r_bit       <= w_nxt_bit;
         r_tx        <= w_nxt_tx;
         r_write     <= w_nxt_write;
         r_rx        <= w_nxt_rx;
         r_ta2       <= w_nxt_ta2;
         r_rsp_valid <= w_nxt_rsp_valid;
         r_rsp_rdata <= w_nxt_rsp_rdata;
         r_rsp_err   <= w_nxt_rsp_err;
         r_mdc       <= w_nxt_mdc;
         r_mdio_o    <= w_nxt_mdio_o;
         r_mdio_t    <= w_nxt_mdio_t;
      end
   end

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_cnt       = r_cnt;
      w_nxt_bit       = r_bit;
      w_nxt_tx        = r_tx;
      w_nxt_write     = r_write;
      w_nxt_rx        = r_rx;
      w_nxt_ta2       = r_ta2;
      w_nxt_rsp_rdata = r_rsp_rdata;
      w_nxt_rsp_err   = r_rsp_err;
      w_nxt_rsp_valid = 1'b0;
      w_nxt_mdc       = 1'b0;
      w_nxt_mdio_o    = 1'b1;
      w_nxt_mdio_t    = 1'b1;

      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               // Serial image after the preamble: ST, OP, PHYAD, REGAD, TA, DATA.
               w_nxt_write = cmd_write;
               w_nxt_tx    = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy, cmd_reg,
                              (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'h0000)};
               w_nxt_rx    = '0;
               w_nxt_ta2   = 1'b0;
               w_nxt_cnt   = '0;
               w_nxt_bit   = '0;
               w_nxt_state = (PREAMBLE_BITS == 0) ? S_HDR : S_PRE;
            end
         end
         S_PRE, S_HDR, S_TA, S_DATA: begin
            w_nxt_cnt = w_bit_end ? 9'd0 : (r_cnt + 9'd1);
            if (w_sample && (r_state == S_TA) && (r_bit == 5'd1)) begin
               w_nxt_ta2 = mdio_i;
            end
            if (w_sample && (r_state == S_DATA)) begin
               w_nxt_rx = {r_rx[14:0], mdio_i};
            end
            if (w_bit_end) begin
               w_nxt_bit = r_bit + 5'd1;
               if (r_state != S_PRE) begin
                  w_nxt_tx = {r_tx[30:0], 1'b0};
               end
               if (r_bit == w_last_bit) begin
                  w_nxt_bit = '0;
                  case (r_state)
                     S_PRE:   w_nxt_state = S_HDR;
                     S_HDR:   w_nxt_state = S_TA;
                     S_TA:    w_nxt_state = S_DATA;
                     default: w_nxt_state = S_DONE;
                  endcase
               end
            end
         end
         S_DONE: w_nxt_state = S_IDLE;
         default: w_nxt_state = S_IDLE;
      endcase

      if ((r_state == S_DATA) && (w_nxt_state == S_DONE)) begin
         w_nxt_rsp_rdata = r_write ? 16'h0000 : r_rx;
         w_nxt_rsp_err   = ~r_write & r_ta2;
      end
      w_nxt_rsp_valid = (w_nxt_state == S_DONE);

      // Outputs are derived from the next state so the pins come straight from flops.
      case (w_nxt_state)
         S_PRE: begin
            w_nxt_mdc    = (w_nxt_cnt >= CNT_HALF);
            w_nxt_mdio_o = 1'b1;
            w_nxt_mdio_t = 1'b0;
         end
         S_HDR: begin
            w_nxt_mdc    = (w_nxt_cnt >= CNT_HALF);
            w_nxt_mdio_o = w_nxt_tx[31];
            w_nxt_mdio_t = 1'b0;
         end
         S_TA, S_DATA: begin
            w_nxt_mdc    = (w_nxt_cnt >= CNT_HALF);
            w_nxt_mdio_o = w_nxt_write ? w_nxt_tx[31] : 1'b1;
            w_nxt_mdio_t = ~w_nxt_write;
         end
         default: begin
            w_nxt_mdc    = 1'b0;
            w_nxt_mdio_o = 1'b1;
            w_nxt_mdio_t = 1'b1;
         end
      endcase
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mdc       = r_mdc;
   assign mdio_o    = r_mdio_o;
   assign mdio_t    = r_mdio_t;

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - directed bench for mdio_master with a cycle-driven PHY model
module tb_mdio_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_write;
   logic [4:0]  cmd_phy;
   logic [4:0]  cmd_reg;
   logic [15:0] cmd_wdata;

   logic        a_valid, a_ready, a_rsp_valid, a_rsp_err, a_mdc, a_mdio_o, a_mdio_t, a_mdio_i;
   logic [15:0] a_rsp_rdata;
   logic        b_valid, b_ready, b_rsp_valid, b_rsp_err, b_mdc, b_mdio_o, b_mdio_t, b_mdio_i;
   logic [15:0] b_rsp_rdata;

   int total;
   int bad;

   logic q_exp_o[$];
   logic q_exp_t[$];
   logic q_obs_o[$];
   logic q_obs_t[$];

   int          resp_cyc;
   logic [15:0] resp_data;
   logic        resp_err;
   logic        acc_ready;
   logic        rdy_at_rsp;
   logic        rdy_after;
   logic [15:0] data_after;
   int          rises;

   mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_write(cmd_write),
      .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
      .mdc(a_mdc), .mdio_o(a_mdio_o), .mdio_t(a_mdio_t), .mdio_i(a_mdio_i)
   );

   mdio_master #(.CLK_DIV(3), .PREAMBLE_BITS(0)) u_dut_nopre (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(cmd_write),
      .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .mdc(b_mdc), .mdio_o(b_mdio_o), .mdio_t(b_mdio_t), .mdio_i(b_mdio_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Call at a falling clk edge; the command is offered in that cycle (cycle 0).
   task automatic run_frame(input bit sel, input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                            input logic [15:0] wd, input logic ta2, input logic [15:0] pdata,
                            input int abort_rise);
      int p, b;
      logic pm, m, o, t, rv, v;
      p = sel ? 0 : 32;
      q_obs_o.delete();
      q_obs_t.delete();
      resp_cyc = -1;
      rises = 0;
      pm = 1'b0;
      cmd_write = wr; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
      if (sel) b_valid = 1'b1; else a_valid = 1'b1;
      acc_ready = sel ? b_ready : a_ready;
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int n = 1; n <= 1200; n++) begin
         m  = sel ? b_mdc : a_mdc;
         o  = sel ? b_mdio_o : a_mdio_o;
         t  = sel ? b_mdio_t : a_mdio_t;
         rv = sel ? b_rsp_valid : a_rsp_valid;
         if (m && !pm) begin
            q_obs_o.push_back(o);
            q_obs_t.push_back(t);
            rises++;
         end
         if (!m && pm) begin
            b = rises % (p + 32);
            if (wr) v = 1'b1;
            else if (b == p + 15) v = ta2;
            else if (b >= p + 16 && b <= p + 31) v = pdata[p + 31 - b];
            else v = 1'b1;
            if (sel) b_mdio_i = v; else a_mdio_i = v;
         end
         pm = m;
         if (abort_rise > 0 && rises >= abort_rise) return;
         if (rv) begin
            resp_cyc   = n;
            resp_data  = sel ? b_rsp_rdata : a_rsp_rdata;
            resp_err   = sel ? b_rsp_err : a_rsp_err;
            rdy_at_rsp = sel ? b_ready : a_ready;
            a_mdio_i = 1'b1;
            b_mdio_i = 1'b1;
            @(posedge clk); #1;
            rdy_after  = sel ? b_ready : a_ready;
            data_after = sel ? b_rsp_rdata : a_rsp_rdata;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total += 7;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
      if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
      if (a_rsp_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", a_rsp_rdata); end
      if (a_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", a_rsp_err); end
      if (a_mdc !== 1'b0) begin bad++; $display("FAIL reset_mdc got=%b exp=0", a_mdc); end
      if (a_mdio_o !== 1'b1) begin bad++; $display("FAIL reset_mdio_o got=%b exp=1", a_mdio_o); end
      if (a_mdio_t !== 1'b1) begin bad++; $display("FAIL reset_mdio_t got=%b exp=1", a_mdio_t); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_read();
      logic e, g;
      @(negedge clk);
      run_frame(1'b0, 1'b0, 5'd1, 5'd1, 16'h0000, 1'b0, 16'h796D, 0);
      for (int i = 0; i < 64; i++) q_exp_t.push_back(i >= 46);
      total += 6;
      if (acc_ready !== 1'b1) begin bad++; $display("FAIL read_accept_ready got=%b exp=1", acc_ready); end
      if (resp_cyc != 257) begin bad++; $display("FAIL read_rsp_cycle got=%0d exp=257", resp_cyc); end
      if (resp_data !== 16'h796D) begin bad++; $display("FAIL read_rdata got=%h exp=796d", resp_data); end
      if (resp_err !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", resp_err); end
      if (rdy_at_rsp !== 1'b0 || rdy_after !== 1'b1) begin
         bad++; $display("FAIL read_ready_seq got=%b%b exp=01", rdy_at_rsp, rdy_after);
      end
      if (data_after !== 16'h796D) begin bad++; $display("FAIL read_rdata_hold got=%h exp=796d", data_after); end
      while (q_exp_t.size() > 0) begin
         e = q_exp_t.pop_front();
         total++;
         if (q_obs_t.size() == 0) begin bad++; $display("FAIL read_mdio_t missing exp=%b", e); end
         else begin
            g = q_obs_t.pop_front();
            if (g !== e) begin bad++; $display("FAIL read_mdio_t bit=%0d got=%b exp=%b", 63 - q_exp_t.size(), g, e); end
         end
      end
   endtask

   task automatic test_write();
      logic [63:0] frame;
      logic e, g;
      frame = 64'hFFFF_FFFF_5182_1140;
      @(negedge clk);
      run_frame(1'b0, 1'b1, 5'd3, 5'd0, 16'h1140, 1'b0, 16'h0000, 0);
      for (int i = 63; i >= 0; i--) begin
         q_exp_o.push_back(frame[i]);
         q_exp_t.push_back(1'b0);
      end
      total += 3;
      if (resp_cyc != 257) begin bad++; $display("FAIL write_rsp_cycle got=%0d exp=257", resp_cyc); end
      if (resp_data !== 16'h0000) begin bad++; $display("FAIL write_rdata got=%h exp=0000", resp_data); end
      if (resp_err !== 1'b0) begin bad++; $display("FAIL write_err got=%b exp=0", resp_err); end
      while (q_exp_o.size() > 0) begin
         e = q_exp_o.pop_front();
         total++;
         if (q_obs_o.size() == 0) begin bad++; $display("FAIL write_mdio_o missing exp=%b", e); end
         else begin
            g = q_obs_o.pop_front();
            if (g !== e) begin bad++; $display("FAIL write_mdio_o bit=%0d got=%b exp=%b", 63 - q_exp_o.size(), g, e); end
         end
      end
      while (q_exp_t.size() > 0) begin
         e = q_exp_t.pop_front();
         total++;
         if (q_obs_t.size() == 0) begin bad++; $display("FAIL write_mdio_t missing exp=%b", e); end
         else begin
            g = q_obs_t.pop_front();
            if (g !== e) begin bad++; $display("FAIL write_mdio_t bit=%0d got=%b exp=%b", 63 - q_exp_t.size(), g, e); end
         end
      end
   endtask

   task automatic test_absent_phy();
      @(negedge clk);
      run_frame(1'b0, 1'b0, 5'd4, 5'd2, 16'h0000, 1'b1, 16'hFFFF, 0);
      total += 3;
      if (resp_cyc != 257) begin bad++; $display("FAIL absent_rsp_cycle got=%0d exp=257", resp_cyc); end
      if (resp_data !== 16'hFFFF) begin bad++; $display("FAIL absent_rdata got=%h exp=ffff", resp_data); end
      if (resp_err !== 1'b1) begin bad++; $display("FAIL absent_err got=%b exp=1", resp_err); end
   endtask

   task automatic test_back_to_back();
      int acc2, r1, r2, rise65, nr, b;
      logic pm, m, drop;
      logic [15:0] pd, d1, d2;
      acc2 = -1; r1 = -1; r2 = -1; rise65 = -1; nr = 0; pm = 1'b0; drop = 1'b0;
      d1 = 16'h0000; d2 = 16'h0000;
      pd = 16'h3C5A;
      @(negedge clk);
      cmd_write = 1'b0; cmd_phy = 5'd1; cmd_reg = 5'd1; cmd_wdata = 16'h0000;
      a_valid = 1'b1;
      total++;
      if (a_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%b exp=1", a_ready); end
      @(posedge clk); #1;
      for (int n = 1; n <= 700; n++) begin
         if (drop) a_valid = 1'b0;
         m = a_mdc;
         if (m && !pm) begin
            nr++;
            if (nr == 65) rise65 = n;
         end
         if (!m && pm) begin
            b = nr % 64;
            if (b == 47) a_mdio_i = 1'b0;
            else if (b >= 48) a_mdio_i = pd[63 - b];
            else a_mdio_i = 1'b1;
         end
         pm = m;
         if (a_valid && a_ready && acc2 < 0) begin acc2 = n; drop = 1'b1; end
         if (a_rsp_valid) begin
            if (r1 < 0) begin r1 = n; d1 = a_rsp_rdata; end
            else if (r2 < 0) begin r2 = n; d2 = a_rsp_rdata; end
         end
         if (r2 >= 0) break;
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
      a_mdio_i = 1'b1;
      @(posedge clk); #1;
      total += 7;
      if (acc2 != 258) begin bad++; $display("FAIL b2b_second_accept got=%0d exp=258", acc2); end
      if (r1 != 257) begin bad++; $display("FAIL b2b_rsp1_cycle got=%0d exp=257", r1); end
      if (r2 != 515) begin bad++; $display("FAIL b2b_rsp2_cycle got=%0d exp=515", r2); end
      if (rise65 != 261) begin bad++; $display("FAIL b2b_frame2_first_rise got=%0d exp=261", rise65); end
      if (nr != 128) begin bad++; $display("FAIL b2b_mdc_rises got=%0d exp=128", nr); end
      if (d1 !== 16'h3C5A) begin bad++; $display("FAIL b2b_rdata1 got=%h exp=3c5a", d1); end
      if (d2 !== 16'h3C5A) begin bad++; $display("FAIL b2b_rdata2 got=%h exp=3c5a", d2); end
   endtask

   task automatic test_reset_mid_frame();
      int seen;
      @(negedge clk);
      run_frame(1'b0, 1'b0, 5'd1, 5'd1, 16'h0000, 1'b0, 16'h1234, 50);
      rst_n = 1'b0;
      #1;
      total += 6;
      if (resp_cyc != -1) begin bad++; $display("FAIL mid_early_rsp got=%0d exp=-1", resp_cyc); end
      if (a_mdc !== 1'b0) begin bad++; $display("FAIL mid_mdc got=%b exp=0", a_mdc); end
      if (a_mdio_t !== 1'b1) begin bad++; $display("FAIL mid_mdio_t got=%b exp=1", a_mdio_t); end
      if (a_mdio_o !== 1'b1) begin bad++; $display("FAIL mid_mdio_o got=%b exp=1", a_mdio_o); end
      if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", a_ready); end
      if (a_rsp_rdata !== 16'h0000) begin bad++; $display("FAIL mid_rdata_clear got=%h exp=0000", a_rsp_rdata); end
      a_mdio_i = 1'b1;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (a_rsp_valid) seen++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1'b0, 1'b0, 5'd1, 5'd1, 16'h0000, 1'b0, 16'h0F0F, 0);
      total += 3;
      if (seen != 0) begin bad++; $display("FAIL mid_rsp_in_reset got=%0d exp=0", seen); end
      if (resp_cyc != 257) begin bad++; $display("FAIL mid_fresh_rsp_cycle got=%0d exp=257", resp_cyc); end
      if (resp_data !== 16'h0F0F) begin bad++; $display("FAIL mid_fresh_rdata got=%h exp=0f0f", resp_data); end
   endtask

   task automatic test_no_preamble();
      logic [13:0] hdr;
      logic e, g;
      hdr = 14'b01100001000101;
      @(negedge clk);
      run_frame(1'b1, 1'b0, 5'd2, 5'd5, 16'h0000, 1'b0, 16'hA5C3, 0);
      for (int i = 13; i >= 0; i--) q_exp_o.push_back(hdr[i]);
      for (int i = 0; i < 32; i++) q_exp_t.push_back(i >= 14);
      total += 3;
      if (resp_cyc != 193) begin bad++; $display("FAIL nopre_rsp_cycle got=%0d exp=193", resp_cyc); end
      if (resp_data !== 16'hA5C3) begin bad++; $display("FAIL nopre_rdata got=%h exp=a5c3", resp_data); end
      if (resp_err !== 1'b0) begin bad++; $display("FAIL nopre_err got=%b exp=0", resp_err); end
      while (q_exp_o.size() > 0) begin
         e = q_exp_o.pop_front();
         total++;
         if (q_obs_o.size() == 0) begin bad++; $display("FAIL nopre_mdio_o missing exp=%b", e); end
         else begin
            g = q_obs_o.pop_front();
            if (g !== e) begin bad++; $display("FAIL nopre_mdio_o bit=%0d got=%b exp=%b", 13 - q_exp_o.size(), g, e); end
         end
      end
      while (q_exp_t.size() > 0) begin
         e = q_exp_t.pop_front();
         total++;
         if (q_obs_t.size() == 0) begin bad++; $display("FAIL nopre_mdio_t missing exp=%b", e); end
         else begin
            g = q_obs_t.pop_front();
            if (g !== e) begin bad++; $display("FAIL nopre_mdio_t bit=%0d got=%b exp=%b", 31 - q_exp_t.size(), g, e); end
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
      a_mdio_i = 1'b1; b_mdio_i = 1'b1;
      cmd_write = 1'b0; cmd_phy = 5'd0; cmd_reg = 5'd0; cmd_wdata = 16'h0000;
      resp_cyc = -1; resp_data = 16'h0000; resp_err = 1'b0;
      acc_ready = 1'b0; rdy_at_rsp = 1'b0; rdy_after = 1'b0; data_after = 16'h0000; rises = 0;
      test_reset();
      test_read();
      test_write();
      test_absent_phy();
      test_back_to_back();
      test_reset_mid_frame();
      test_no_preamble();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
